// File: rtl/adder_arbiter_pkg.sv
// Shared types and default parameters for the adder arbiter slice.
// Latency: none (types only).
// Backpressure: n/a.
package adder_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int SUM_W_DEF   = 9;
    localparam int ADD_LAT_DEF = 1;

    // Index field sized for the largest supported requester count (8),
    // so one tag type serves every legal N_REQ.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } arb_tag_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bundle: operand requests in, sums back out.
// Latency: none (wiring only).
// Backpressure: req_rdy grants requests; rsp side has no backpressure.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
);
    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ-1:0]        req_rdy;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        rsp_vld;
    logic [SUM_W-1:0]        rsp_data;

    modport master (output req_vld, req_a, req_b, input req_rdy, rsp_vld, rsp_data);
    modport slave  (input req_vld, req_a, req_b, output req_rdy, rsp_vld, rsp_data);
endinterface

// File: rtl/adder_arbiter_rr_grant.sv
// Round-robin picker: first requester after last_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller masks the grant.
module rr_grant
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);
    localparam int PW = $clog2(N_REQ);

    always_comb begin
        logic          found;
        logic [PW-1:0] pos;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = PW'((int'(last_ptr) + k) % N_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = IDX_W'(pos);
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder among N_REQ requesters, round-robin, routing sums back by tag.
// Latency: handshake at t -> add_in at t+1 -> rsp_vld at t+ADD_LAT+2.
// Backpressure: one grant per cycle via req_rdy; none while paused or draining; rsp has none.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SUM_W   = SUM_W_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    adder_arbiter_if.slave     req_if,
    output logic               add_in_vld,
    output logic [DATA_W-1:0]  add_in0,
    output logic [DATA_W-1:0]  add_in1,
    input  logic               add_out_vld,
    input  logic [SUM_W-1:0]   add_out,
    input  logic               pause,
    output logic               busy,
    output logic               err_sync
);
    arb_state_e       state;
    logic [IDX_W-1:0] last_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] issue_idx;
    logic [N_REQ-1:0] gnt_pick;
    logic             grant_en;
    logic             xfer;
    logic             tag_any;
    logic             pipe_empty;
    arb_tag_t         tags [ADD_LAT];
    arb_tag_t         head;

    rr_grant #(.N_REQ(N_REQ)) u_rr_grant (
        .req       (req_if.req_vld),
        .last_ptr  (last_ptr),
        .grant     (gnt_pick),
        .grant_idx (gnt_idx)
    );

    assign grant_en       = !pause && (state != DRAIN);
    assign req_if.req_rdy = grant_en ? gnt_pick : '0;
    assign xfer           = |req_if.req_rdy;
    assign head           = tags[ADD_LAT-1];

    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i < ADD_LAT; i++) begin
            tag_any = tag_any | tags[i].vld;
        end
    end

    assign pipe_empty = !add_in_vld && !tag_any;
    assign busy       = !pipe_empty || (|req_if.rsp_vld);

    always_ff @(posedge clk) begin
        if (rst) begin
            add_in_vld <= 1'b0;
            add_in0    <= '0;
            add_in1    <= '0;
            issue_idx  <= '0;
            last_ptr   <= IDX_W'(N_REQ - 1);
        end else begin
            add_in_vld <= xfer;
            if (xfer) begin
                add_in0   <= req_if.req_a[gnt_idx*DATA_W +: DATA_W];
                add_in1   <= req_if.req_b[gnt_idx*DATA_W +: DATA_W];
                issue_idx <= gnt_idx;
                last_ptr  <= gnt_idx;
            end
        end
    end

    // Tags trail add_in_vld so the head lines up with the adder's output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ADD_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{vld: add_in_vld, idx: issue_idx};
            for (int i = 1; i < ADD_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_if.rsp_vld  <= '0;
            req_if.rsp_data <= '0;
            err_sync        <= 1'b0;
        end else begin
            req_if.rsp_vld <= '0;
            if (head.vld && add_out_vld) begin
                req_if.rsp_vld  <= N_REQ'(1) << head.idx;
                req_if.rsp_data <= add_out;
            end
            if (head.vld != add_out_vld) begin
                err_sync <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (xfer) state <= RUN;
                RUN: begin
                    if (pause && busy)       state <= DRAIN;
                    else if (!xfer && !busy) state <= IDLE;
                end
                DRAIN:   if (pipe_empty) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
